// File: rtl/rv32_pkg.sv
// Shared RV32I encodings for the multi-cycle control path: opcodes, FSM state
// codes, trap causes and the reset instruction.
package rv32_pkg;

    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_LOAD  = 7'h03;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_LUI   = 7'h37;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_IMEM    = 2'b10;
    localparam logic [1:0] TRAP_DMEM    = 2'b11;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
            OP_JALR, OP_JAL, OP_AUIPC, OP_LUI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/req_timeout_timer.sv
// Counts request cycles that went unacknowledged; expired flags the cycle in
// which the TIMEOUT-th consecutive miss happens.
module req_timeout_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + W'(1);
        end
    end

    // A miss in this cycle is the one that brings the count to TIMEOUT.
    assign expired = count_en && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb stepping with
// handshake timeouts, illegal-opcode trap, and cycle/instret counters.
module multicycle_sequencer
    import rv32_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned TIMEOUT    = 16,
    parameter bit          RESET_TRAP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir_q,
    input  logic             cu_regwr,
    input  logic             cu_memwr,
    input  logic             cu_memtoreg,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ld_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [2:0]       state_q, state_d;
    logic [31:0]      ir_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    logic in_fetch, in_mem, in_wb, in_trap;
    logic tmr_clear, tmr_count_en, tmr_expired;

    assign in_fetch = (state_q == ST_FETCH);
    assign in_mem   = (state_q == ST_MEM);
    assign in_wb    = (state_q == ST_WB);
    assign in_trap  = (state_q == ST_TRAP);

    // Held at zero outside the two wait states, so every entry starts fresh.
    assign tmr_clear    = !(in_fetch || in_mem);
    assign tmr_count_en = (in_fetch && !imem_ack) || (in_mem && !dmem_ack);

    req_timeout_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (tmr_clear),
        .count_en (tmr_count_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cause_d = cause_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_IMEM;
                end
            end
            ST_DECODE: begin
                if (is_legal_opcode(ir_q[6:0])) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_ILLEGAL;
                end
            end
            ST_EXEC: state_d = (cu_memwr || cu_memtoreg) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (dmem_ack) begin
                    state_d = ST_WB;
                end else if (tmr_expired) begin
                    state_d = ST_TRAP;
                    cause_d = TRAP_DMEM;
                end
            end
            ST_WB:   state_d = ST_FETCH;
            default: state_d = ST_TRAP;
        endcase
    end

    always_comb begin
        cycle_cnt_d   = in_trap ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
        instret_cnt_d = in_wb ? instret_cnt_q + CNT_W'(1) : instret_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RESET_TRAP ? ST_TRAP : ST_FETCH;
            ir_q          <= NOP_INST;
            cause_q       <= TRAP_NONE;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            cause_q       <= cause_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign imem_req    = in_fetch;
    assign dmem_req    = in_mem;
    assign dmem_we     = in_mem && cu_memwr;
    assign ld_we       = in_mem && dmem_ack && cu_memtoreg;
    assign pc_we       = in_wb;
    assign rf_we       = in_wb && cu_regwr;
    assign halted      = in_trap;
    assign trap_cause  = cause_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: a per-instruction trace model builds the expected
// cycle-by-cycle outputs, then one process replays the stimulus and compares.
module tb_multicycle_sequencer;

    localparam int unsigned CW = 8;
    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic          cu_regwr = 1'b0, cu_memwr = 1'b0, cu_memtoreg = 1'b0;
    logic          dmem_ack = 1'b0;

    logic          imem_req, dmem_req, dmem_we, ld_we, pc_we, rf_we, halted;
    logic [31:0]   ir_q;
    logic [1:0]    trap_cause;
    logic [CW-1:0] cycle_cnt, instret_cnt;

    logic          imem_req2, dmem_req2, dmem_we2, ld_we2, pc_we2, rf_we2, halted2;
    logic [31:0]   ir_q2;
    logic [1:0]    trap_cause2;
    logic [CW-1:0] cycle_cnt2, instret_cnt2;

    multicycle_sequencer #(.CNT_W(CW), .TIMEOUT(TO), .RESET_TRAP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir_q(ir_q), .cu_regwr(cu_regwr), .cu_memwr(cu_memwr),
        .cu_memtoreg(cu_memtoreg), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_ack(dmem_ack), .ld_we(ld_we), .pc_we(pc_we), .rf_we(rf_we),
        .halted(halted), .trap_cause(trap_cause), .cycle_cnt(cycle_cnt),
        .instret_cnt(instret_cnt)
    );

    multicycle_sequencer #(.CNT_W(CW), .TIMEOUT(TO), .RESET_TRAP(1'b1)) dut_halt (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir_q(ir_q2), .cu_regwr(cu_regwr), .cu_memwr(cu_memwr),
        .cu_memtoreg(cu_memtoreg), .dmem_req(dmem_req2), .dmem_we(dmem_we2),
        .dmem_ack(dmem_ack), .ld_we(ld_we2), .pc_we(pc_we2), .rf_we(rf_we2),
        .halted(halted2), .trap_cause(trap_cause2), .cycle_cnt(cycle_cnt2),
        .instret_cnt(instret_cnt2)
    );

    typedef struct {
        bit            rst;
        bit            iack, dack;
        logic [31:0]   rdata;
        bit            rw, mw, mr;
        bit            ireq, dreq, dwe, ldwe, pcwe, rfwe, halt;
        logic [1:0]    cause;
        logic [CW-1:0] cyc, iret;
        logic [31:0]   ir;
    } rec_t;

    rec_t q[$];

    logic [CW-1:0] m_cyc, m_iret;
    logic [31:0]   m_ir;
    bit            m_halt;
    logic [1:0]    m_cause;
    bit            c_rw, c_mw, c_mr;

    int unsigned n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h17, 7'h37};
    endfunction

    // Stand-in for control_unit: stores write memory, loads read it, branches and
    // stores leave the register file alone.
    task automatic set_cu(input logic [31:0] inst);
        c_mw = (inst[6:0] == 7'h23);
        c_mr = (inst[6:0] == 7'h03);
        c_rw = !((inst[6:0] == 7'h23) || (inst[6:0] == 7'h63));
    endtask

    task automatic step(input bit ireq, input bit iack, input bit dreq, input bit dack,
                        input bit pcwe, input logic [31:0] rdata);
        rec_t r;
        r.rst = 1'b0; r.iack = iack; r.dack = dack; r.rdata = rdata;
        r.rw = c_rw; r.mw = c_mw; r.mr = c_mr;
        r.ireq = ireq; r.dreq = dreq; r.dwe = dreq & c_mw; r.ldwe = dreq & dack & c_mr;
        r.pcwe = pcwe; r.rfwe = pcwe & c_rw; r.halt = m_halt; r.cause = m_cause;
        r.cyc = m_cyc; r.iret = m_iret; r.ir = m_ir;
        q.push_back(r);
        if (!m_halt) m_cyc++;
    endtask

    task automatic do_reset();
        rec_t r;
        r = '{default: '0};
        r.rst = 1'b1; r.iack = 1'b1; r.dack = 1'b1; r.rdata = 32'hDEAD_BEEF;
        q.push_back(r);
        m_cyc = '0; m_iret = '0; m_ir = 32'h0000_0013; m_halt = 0; m_cause = 2'b00;
        c_rw = 0; c_mw = 0; c_mr = 0;
    endtask

    task automatic trap_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0037);
    endtask

    // One instruction: iw/dw are the unacked wait cycles before each ack;
    // cut>0 stops the trace after that many MEM cycles (for mid-access reset).
    task automatic run_inst(input logic [31:0] inst, input int iw, input int dw,
                            input int cut, output int wb_at);
        wb_at = -1;
        set_cu(inst);
        for (int i = 0; i <= iw; i++) begin
            if (i == iw) begin
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, inst);
                m_ir = inst;
            end else begin
                step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, inst);
                if (i + 1 == TO) begin m_halt = 1; m_cause = 2'b10; return; end
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        if (!legal(inst[6:0])) begin m_halt = 1; m_cause = 2'b01; return; end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        if (c_mw || c_mr) begin
            for (int i = 0; i <= dw; i++) begin
                if (cut != 0 && i == cut) return;
                if (i == dw) begin
                    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
                end else begin
                    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
                    if (i + 1 == TO) begin m_halt = 1; m_cause = 2'b11; return; end
                end
            end
        end
        wb_at = q.size();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        m_iret++;
    endtask

    logic [31:0] prog [9] = '{32'h00500093, 32'h0000A103, 32'h0020A023, 32'h00208463,
                              32'h0000006F, 32'h123450B7, 32'h00001117, 32'h000080E7,
                              32'h002081B3};

    initial begin
        int base, wb;
        rec_t r;

        do_reset(); do_reset();

        base = q.size();
        run_inst(32'h00500093, 0, 0, 0, wb);
        chk("pin_addi_wb_cycle", 32'(wb - base + 1), 32'd4);
        chk("pin_addi_cycle_cnt", m_cyc, 32'd4);
        chk("pin_addi_instret", m_iret, 32'd1);

        base = q.size();
        run_inst(32'h0000A103, 0, 2, 0, wb);
        chk("pin_lw_wb_cycle", 32'(wb - base + 1), 32'd7);
        chk("pin_lw_ldwe_before_wb", 32'(q[wb - 1].ldwe), 32'd1);

        run_inst(32'h0020A023, 1, 0, 0, wb);
        chk("pin_sw_rfwe", 32'(q[wb].rfwe), 32'd0);
        chk("pin_sw_dwe", 32'(q[wb - 1].dwe), 32'd1);

        run_inst(32'h00500093, 3, 0, 0, wb);
        chk("pin_ack_on_last_wait", 32'(m_halt), 32'd0);

        for (int i = 0; i < 300; i++) run_inst(prog[i % 9], i % 3, (i / 3) % 2, 0, wb);

        run_inst(32'h0000A103, 0, 9, 2, wb);
        do_reset();
        run_inst(32'h00500093, 0, 0, 0, wb);

        run_inst(32'h00000000, 0, 0, 0, wb);
        chk("pin_illegal_cause", m_cause, 32'd1);
        trap_cycles(5);

        do_reset();
        run_inst(32'h00500093, 20, 0, 0, wb);
        chk("pin_imem_timeout_cause", m_cause, 32'd2);
        chk("pin_imem_timeout_cycles", m_cyc, 32'd4);
        trap_cycles(4);

        do_reset();
        run_inst(32'h0000A103, 0, 20, 0, wb);
        chk("pin_dmem_timeout_cause", m_cause, 32'd3);
        trap_cycles(4);

        do_reset();
        run_inst(32'h00500093, 1, 0, 0, wb);

        while (q.size() > 0) begin
            r = q.pop_front();
            @(negedge clk);
            rst_n = !r.rst; imem_ack = r.iack; dmem_ack = r.dack; imem_rdata = r.rdata;
            cu_regwr = r.rw; cu_memwr = r.mw; cu_memtoreg = r.mr;
            #1;
            if (!r.rst) begin
                chk("imem_req", imem_req, r.ireq);
                chk("dmem_req", dmem_req, r.dreq);
                chk("dmem_we", dmem_we, r.dwe);
                chk("ld_we", ld_we, r.ldwe);
                chk("pc_we", pc_we, r.pcwe);
                chk("rf_we", rf_we, r.rfwe);
                chk("halted", halted, r.halt);
                chk("trap_cause", trap_cause, r.cause);
                chk("cycle_cnt", cycle_cnt, r.cyc);
                chk("instret_cnt", instret_cnt, r.iret);
                chk("ir_q", ir_q, r.ir);
                chk("rt_halted", halted2, 1'b1);
                chk("rt_strobes", {imem_req2, dmem_req2, dmem_we2, ld_we2, pc_we2, rf_we2}, 6'b0);
                chk("rt_counters", {trap_cause2, cycle_cnt2, instret_cnt2}, '0);
                chk("rt_ir_q", ir_q2, 32'h0000_0013);
            end
        end
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
